// File: rtl/nw_strategy_arb_pkg.sv
// Package: nw_strategy_arb_pkg
// Shared types and helpers for the strategy arbiter.
//   arb_strategy_e : run-time arbitration policy (RSVD behaves as RR)
//   arb_state_e    : arbiter FSM states
//   onehot2idx     : index of the set bit of a one-hot vector (up to MAX_REQ wide)
package nw_strategy_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'd0,
        ARB_RR    = 2'd1,
        ARB_WRR   = 2'd2,
        ARB_RSVD  = 2'd3
    } arb_strategy_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Returns 0 for an all-zero vector.
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nw_strategy_arbiter_rr_pick.sv
// Module: nw_arb_rr_pick
// Combinational masked round-robin picker.
//   vec : candidate vector
//   ptr : last winner; search starts at ptr+1 and wraps N-1 -> 0
//   win : one-hot winner (zero when vec is zero)
// With ptr = N-1 the search starts at 0, giving fixed lowest-index priority.
module nw_arb_rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         win
);

    localparam int unsigned W = $clog2(N);

    logic         found;
    logic [W-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = W'((32'(ptr) + k) % N);
            if (!found && vec[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nw_strategy_arbiter.sv
// Module: nw_strategy_arbiter
// N-requester arbiter for one shared resource with a run-time selectable policy
// (fixed priority, round robin, weighted round robin). Owns the grant and its release.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_i           : request vector, held until done_i or abandoned
//   done_i          : owner finished; releases the grant
//   cfg_strategy_i  : 0=FIXED 1=RR 2=WRR 3=reserved (RR)
//   cfg_weight_i    : per-requester weight, 0 treated as 1
//   cfg_apply_i     : pulse; latch strategy/weights into shadow registers
//   gnt_o, gnt_id_o : registered one-hot grant and owner index (0 when idle)
//   busy_o          : resource granted
//   cfg_pend_o      : shadow config latched but not yet active
// Optional build macro NW_STRATEGY_ARB_STATS_EN adds stat_clr_i / stat_cnt_o
// (saturating per-requester grant counters).
module nw_strategy_arbiter
    import nw_strategy_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WGT_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     done_i,
    input  logic [1:0]               cfg_strategy_i,
    input  logic [N_REQ*WGT_W-1:0]   cfg_weight_i,
    input  logic                     cfg_apply_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] gnt_id_o,
    output logic                     busy_o,
`ifdef NW_STRATEGY_ARB_STATS_EN
    input  logic                     stat_clr_i,
    output logic [N_REQ*CNT_W-1:0]   stat_cnt_o,
`endif
    output logic                     cfg_pend_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ*WGT_W-1:0] WGT_ONES = {N_REQ{WGT_W'(1)}};

    if (N_REQ < 2 || N_REQ > MAX_REQ || WGT_W < 1 || CNT_W < 1) begin : g_param_check
        $error("nw_strategy_arbiter: parameter out of range");
    end

    arb_state_e            state_q;
    logic [N_REQ-1:0]      gnt_q;
    logic [IDX_W-1:0]      gnt_id_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    arb_strategy_e         strat_q;
    arb_strategy_e         shd_strat_q;
    logic [N_REQ*WGT_W-1:0] wgt_q;
    logic [N_REQ*WGT_W-1:0] shd_wgt_q;
    logic                  pend_q;
    logic [WGT_W-1:0]      cred_q [N_REQ];

    logic                  owner_req;
    logic                  release_pt;
    logic                  arb_pt;
    logic                  take_cfg;
    logic                  reload;
    logic                  grant_fire;
    arb_strategy_e         eff_strat;
    logic [N_REQ*WGT_W-1:0] eff_wgt;
    logic [WGT_W-1:0]      load_val  [N_REQ];
    logic [WGT_W-1:0]      cred_base [N_REQ];
    logic [WGT_W-1:0]      cred_d    [N_REQ];
    logic [N_REQ-1:0]      cand;
    logic [N_REQ-1:0]      pick_vec;
    logic [IDX_W-1:0]      pick_ptr;
    logic [N_REQ-1:0]      win;
    logic [IDX_W-1:0]      win_id;
    logic [MAX_REQ-1:0]    win_ext;

    // Arbitration point: idle, or the owner releases this cycle. A pending config
    // becomes effective here, so the pick in this same cycle already uses it.
    always_comb begin
        owner_req  = req_i[gnt_id_q];
        release_pt = (state_q == ARB_GRANT) && (done_i || !owner_req);
        arb_pt     = (state_q == ARB_IDLE) || release_pt;
        take_cfg   = arb_pt && pend_q;
        eff_strat  = take_cfg ? shd_strat_q : strat_q;
        eff_wgt    = take_cfg ? shd_wgt_q : wgt_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            load_val[i] = eff_wgt[i*WGT_W +: WGT_W];
            if (load_val[i] == '0) load_val[i] = WGT_W'(1);
            cred_base[i] = take_cfg ? load_val[i] : cred_q[i];
            cand[i]      = req_i[i] && (cred_base[i] != '0);
        end
        // WRR with every requester out of credit: reload and pick in the same cycle.
        reload   = (eff_strat == ARB_WRR) && (cand == '0) && (req_i != '0);
        pick_vec = req_i;
        if (eff_strat == ARB_WRR && !reload) pick_vec = cand;
        pick_ptr   = (eff_strat == ARB_FIXED) ? IDX_W'(N_REQ - 1) : rr_ptr_q;
        grant_fire = arb_pt && (req_i != '0);
    end

    nw_arb_rr_pick #(
        .N   (N_REQ)
    ) u_pick (
        .vec (pick_vec),
        .ptr (pick_ptr),
        .win (win)
    );

    always_comb begin
        win_ext              = '0;
        win_ext[N_REQ-1:0]   = win;
        win_id               = IDX_W'(onehot2idx(win_ext));
        for (int i = 0; i < int'(N_REQ); i++) begin
            cred_d[i] = cred_q[i];
            if (arb_pt) begin
                cred_d[i] = reload ? load_val[i] : cred_base[i];
                if (eff_strat == ARB_WRR && grant_fire && win[i]) begin
                    cred_d[i] = cred_d[i] - WGT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            rr_ptr_q    <= IDX_W'(N_REQ - 1);
            strat_q     <= ARB_RR;
            shd_strat_q <= ARB_RR;
            wgt_q       <= WGT_ONES;
            shd_wgt_q   <= WGT_ONES;
            pend_q      <= 1'b0;
            for (int i = 0; i < int'(N_REQ); i++) cred_q[i] <= '0;
        end else begin
            if (arb_pt) begin
                if (grant_fire) begin
                    state_q  <= ARB_GRANT;
                    gnt_q    <= win;
                    gnt_id_q <= win_id;
                    rr_ptr_q <= win_id;
                end else begin
                    state_q  <= ARB_IDLE;
                    gnt_q    <= '0;
                    gnt_id_q <= '0;
                end
            end
            if (take_cfg) begin
                strat_q <= shd_strat_q;
                wgt_q   <= shd_wgt_q;
            end
            // A new apply in the same cycle keeps the pending flag for the newer value.
            if (cfg_apply_i) begin
                shd_strat_q <= arb_strategy_e'(cfg_strategy_i);
                shd_wgt_q   <= cfg_weight_i;
                pend_q      <= 1'b1;
            end else if (take_cfg) begin
                pend_q <= 1'b0;
            end
            for (int i = 0; i < int'(N_REQ); i++) cred_q[i] <= cred_d[i];
        end
    end

    assign gnt_o      = gnt_q;
    assign gnt_id_o   = gnt_id_q;
    assign busy_o     = (state_q == ARB_GRANT);
    assign cfg_pend_o = pend_q;

`ifdef NW_STRATEGY_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_REQ); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (stat_clr_i) begin
                    cnt_q[i] <= '0;
                end else if (grant_fire && win[i] && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        for (int i = 0; i < int'(N_REQ); i++) stat_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule
